// File: rtl/matmul_pkg.sv
// matmul_pkg
// Shared configuration for the FeedForward matrix multiplier and its
// sequencer. Both sides import the same sizes so the flattened operand and
// result buses always agree in width and element ordering.
//   N       rows of A and C
//   DIN     columns of A / rows of B
//   DOUT    columns of B and C
//   WIDTH   signed operand element width (results are 2*WIDTH)
//   TIMEOUT maximum WAIT cycles before a job is abandoned
package matmul_pkg;

  localparam int N       = 3;
  localparam int DIN     = 3;
  localparam int DOUT    = 3;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 64;

  localparam int A_ELEMS  = N * DIN;
  localparam int B_ELEMS  = DIN * DOUT;
  localparam int C_ELEMS  = N * DOUT;
  localparam int AB_ELEMS = A_ELEMS + B_ELEMS;
  localparam int C_WIDTH  = 2 * WIDTH;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // idx walks the operand load and the result drain, so it must cover both.
  localparam int IDX_W  = $clog2(max_int(AB_ELEMS, C_ELEMS));
  localparam int WCNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    KICK  = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/matmul_sequencer_if.sv
// matmul_sequencer_if
// Bundles every signal of the sequencer except clock and reset.
//   operand stream : in_valid, in_ready, in_data
//   multiplier bus : mm_start, mm_done, mm_a, mm_b, mm_c
//   result stream  : out_valid, out_ready, out_data, out_last
//   status         : busy, timeout_err, dbg_state (FSM state for checkers)
// Streams use valid/ready: a transfer happens on a rising clock edge where
// both valid and ready are high; once valid is raised, the data (and last)
// stay constant until that transfer happens.
// master = the sequencer, slave = the environment (source, sink, multiplier).
interface matmul_sequencer_if;
  import matmul_pkg::*;

  logic                       in_valid;
  logic                       in_ready;
  logic [WIDTH-1:0]           in_data;
  logic                       mm_start;
  logic                       mm_done;
  logic [A_ELEMS*WIDTH-1:0]   mm_a;
  logic [B_ELEMS*WIDTH-1:0]   mm_b;
  logic [C_ELEMS*C_WIDTH-1:0] mm_c;
  logic                       out_valid;
  logic                       out_ready;
  logic [C_WIDTH-1:0]         out_data;
  logic                       out_last;
  logic                       busy;
  logic                       timeout_err;
  state_t                     dbg_state;

  modport master (
    input  in_valid, in_data, mm_done, mm_c, out_ready,
    output in_ready, mm_start, mm_a, mm_b, out_valid, out_data, out_last,
           busy, timeout_err, dbg_state
  );

  modport slave (
    output in_valid, in_data, mm_done, mm_c, out_ready,
    input  in_ready, mm_start, mm_a, mm_b, out_valid, out_data, out_last,
           busy, timeout_err, dbg_state
  );

endinterface

// File: rtl/matmul_sequencer.sv
// matmul_sequencer
// Initiator-side controller for the START/DONE matrix multiplier. Loads A
// then B (row-major) from the operand stream, pulses START, waits for DONE
// (bounded by TIMEOUT), captures C and streams it out row-major.
// Ports:
//   clk   clock
//   reset asynchronous active-high reset
//   bus   matmul_sequencer_if.master (operand stream, multiplier bus,
//         result stream, busy/timeout_err status, dbg_state)
module matmul_sequencer
  import matmul_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  matmul_sequencer_if.master  bus
);

  localparam logic [IDX_W-1:0]  IDX_AB_LAST = IDX_W'(AB_ELEMS - 1);
  localparam logic [IDX_W-1:0]  IDX_C_LAST  = IDX_W'(C_ELEMS - 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST   = WCNT_W'(TIMEOUT - 1);

  state_t                     state;
  logic [IDX_W-1:0]           idx;
  logic [WCNT_W-1:0]          wcnt;
  // A occupies the low elements and B the high ones, so a single running
  // idx addresses both during the load.
  logic [AB_ELEMS*WIDTH-1:0]  ab_buf;
  logic [C_ELEMS*C_WIDTH-1:0] c_buf;

  logic                       in_ready_q;
  logic                       mm_start_q;
  logic                       out_valid_q;
  logic [C_WIDTH-1:0]         out_data_q;
  logic                       out_last_q;
  logic                       busy_q;
  logic                       timeout_err_q;

  logic [IDX_W-1:0]           idx_nxt;
  assign idx_nxt = idx + IDX_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= LOAD;
      idx           <= '0;
      wcnt          <= '0;
      ab_buf        <= '0;
      c_buf         <= '0;
      in_ready_q    <= 1'b1;
      mm_start_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          // in_ready is high throughout LOAD, so valid alone is a transfer.
          if (bus.in_valid) begin
            ab_buf[int'(idx)*WIDTH +: WIDTH] <= bus.in_data;
            timeout_err_q <= 1'b0;
            if (idx == IDX_AB_LAST) begin
              idx        <= '0;
              state      <= KICK;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
              mm_start_q <= 1'b1;
            end else begin
              idx <= idx_nxt;
            end
          end
        end

        KICK: begin
          mm_start_q <= 1'b0;
          wcnt       <= '0;
          state      <= WAIT;
        end

        WAIT: begin
          // wcnt==0 is the first WAIT cycle: a DONE left over from the
          // previous job can still be high there, so it is not trusted.
          if (wcnt != '0 && bus.mm_done) begin
            c_buf       <= bus.mm_c;
            idx         <= '0;
            out_valid_q <= 1'b1;
            out_data_q  <= bus.mm_c[C_WIDTH-1:0];
            out_last_q  <= (C_ELEMS == 1);
            state       <= DRAIN;
          end else if (wcnt == WCNT_LAST) begin
            timeout_err_q <= 1'b1;
            idx           <= '0;
            in_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
            state         <= LOAD;
          end else begin
            wcnt <= wcnt + WCNT_W'(1);
          end
        end

        DRAIN: begin
          if (bus.out_ready) begin
            if (idx == IDX_C_LAST) begin
              idx         <= '0;
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              out_last_q  <= 1'b0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
              state       <= LOAD;
            end else begin
              idx        <= idx_nxt;
              out_data_q <= c_buf[int'(idx_nxt)*C_WIDTH +: C_WIDTH];
              out_last_q <= (idx_nxt == IDX_C_LAST);
            end
          end
        end

        default: state <= LOAD;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.mm_start    = mm_start_q;
  assign bus.mm_a        = ab_buf[A_ELEMS*WIDTH-1:0];
  assign bus.mm_b        = ab_buf[AB_ELEMS*WIDTH-1:A_ELEMS*WIDTH];
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_last    = out_last_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_matmul_sequencer.sv
module tb_matmul_sequencer;
  import matmul_pkg::*;

  localparam int DW       = C_WIDTH;
  localparam int M_NORMAL = 0;
  localparam int M_STALE  = 1;
  localparam int M_NEVER  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  matmul_sequencer_if bus();

  matmul_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- bench state ----------------
  int tests = 0;
  int fails = 0;
  logic [DW-1:0] exp_q[$];
  int start_cnt = 0;
  int mult_mode = M_NORMAL;
  int done_delay = 3;
  logic [WIDTH-1:0] job_a[A_ELEMS];
  logic [WIDTH-1:0] job_b[B_ELEMS];
  logic [A_ELEMS*WIDTH-1:0] a_flat;
  logic [B_ELEMS*WIDTH-1:0] b_flat;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plain integer matrix product, truncated to the result element width.
  function automatic logic [C_ELEMS*DW-1:0] matmul(input logic [A_ELEMS*WIDTH-1:0] a,
                                                   input logic [B_ELEMS*WIDTH-1:0] b);
    logic [C_ELEMS*DW-1:0] r;
    logic signed [WIDTH-1:0] x, y;
    int acc;
    r = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < DOUT; j++) begin
        acc = 0;
        for (int k = 0; k < DIN; k++) begin
          x = a[(i*DIN+k)*WIDTH +: WIDTH];
          y = b[(k*DOUT+j)*WIDTH +: WIDTH];
          acc += int'(x) * int'(y);
        end
        r[(i*DOUT+j)*DW +: DW] = acc[DW-1:0];
      end
    end
    return r;
  endfunction

  always @(negedge clk) if (bus.mm_start) start_cnt++;

  // ---------------- behavioural multiplier ----------------
  initial begin
    logic [C_ELEMS*DW-1:0] c;
    bus.mm_done = 1'b0;
    bus.mm_c    = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.mm_start && mult_mode == M_NORMAL) begin
        c = matmul(bus.mm_a, bus.mm_b);
        repeat (done_delay) @(posedge clk);
        #1;
        bus.mm_c    = c;
        bus.mm_done = 1'b1;
        @(posedge clk); #1;
        bus.mm_done = 1'b0;
      end else if (bus.mm_start && mult_mode == M_STALE) begin
        c = matmul(bus.mm_a, bus.mm_b);
        @(posedge clk); #1;            // stale DONE still high in first WAIT cycle
        @(posedge clk); #1;
        bus.mm_done = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.mm_c    = c;
        bus.mm_done = 1'b1;
        @(posedge clk); #1;
        bus.mm_done = 1'b0;
      end else if (!bus.mm_start) begin
        bus.mm_done = (mult_mode == M_STALE);
        if (mult_mode == M_STALE) bus.mm_c = {C_ELEMS{16'hDEAD}};
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_elem(input logic [WIDTH-1:0] d);
    int g;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    g = 0;
    while (!bus.in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("in_ready_wait", bus.in_ready, 1'b1);
    @(posedge clk);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
  endtask

  // gap: 0 none, 1 alternate idle cycles, 2 random idle cycles
  task automatic send_job(input int gap, input bit push, input bit check_clear);
    logic [C_ELEMS*DW-1:0] c;
    for (int i = 0; i < A_ELEMS; i++) a_flat[i*WIDTH +: WIDTH] = job_a[i];
    for (int i = 0; i < B_ELEMS; i++) b_flat[i*WIDTH +: WIDTH] = job_b[i];
    if (push) begin
      c = matmul(a_flat, b_flat);
      for (int e = 0; e < C_ELEMS; e++) exp_q.push_back(c[e*DW +: DW]);
    end
    for (int i = 0; i < AB_ELEMS; i++) begin
      send_elem((i < A_ELEMS) ? job_a[i] : job_b[i-A_ELEMS]);
      if (i == 0 && check_clear) begin
        #1;
        check("timeout_err_cleared", bus.timeout_err, 1'b0);
      end
      if (i != AB_ELEMS-1) begin
        if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) idle_cycle();
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_start();
    int g;
    g = 0;
    while (!bus.mm_start && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    check("mm_start_seen", bus.mm_start, 1'b1);
  endtask

  // ---------------- scoreboard / sink ----------------
  // mode: 0 always ready, 1 ready pattern 1,0,0,1 over valid cycles, 2 random
  task automatic drain(input int mode, input int n);
    int hs, cyc, vcyc;
    logic stalled, r, exp_last, held_l;
    logic [DW-1:0] held_d, e;
    hs = 0; cyc = 0; vcyc = 0; stalled = 1'b0; held_d = '0; held_l = 1'b0;
    while (hs < n && cyc < 600) begin
      @(negedge clk);
      if (stalled) begin
        check("hold_valid", bus.out_valid, 1'b1);
        check("hold_data", bus.out_data, held_d);
        check("hold_last", bus.out_last, held_l);
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = (vcyc % 4 == 0) || (vcyc % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = r;
      stalled = 1'b0;
      if (bus.out_valid) begin
        vcyc++;
        if (r) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL extra_output: observed %0h expected none", bus.out_data);
          end else begin
            exp_last = (exp_q.size() == 1);
            e = exp_q.pop_front();
            check("out_data", bus.out_data, e);
            check("out_last", bus.out_last, exp_last);
          end
          hs++;
        end else begin
          stalled = 1'b1;
          held_d  = bus.out_data;
          held_l  = bus.out_last;
        end
      end
      cyc++;
    end
    check("drain_count", hs, n);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic random_operands();
    for (int i = 0; i < A_ELEMS; i++) job_a[i] = WIDTH'($urandom);
    for (int i = 0; i < B_ELEMS; i++) job_b[i] = WIDTH'($urandom);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int s0;
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #12;
    check("rst_mm_start", bus.mm_start, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_last", bus.out_last, 1'b0);
    check("rst_out_data", bus.out_data, '0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_timeout_err", bus.timeout_err, 1'b0);
    check("rst_mm_a", bus.mm_a, '0);
    check("rst_mm_b", bus.mm_b, '0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_state", bus.dbg_state, LOAD);
    @(negedge clk);
    reset = 1'b0;

    // identity
    for (int i = 0; i < A_ELEMS; i++) job_a[i] = WIDTH'(i + 1);
    for (int k = 0; k < DIN; k++)
      for (int j = 0; j < DOUT; j++) job_b[k*DOUT+j] = (k == j) ? WIDTH'(1) : WIDTH'(0);
    s0 = start_cnt;
    send_job(0, 1'b1, 1'b0);
    check("ident_busy_during", bus.busy, 1'b1);
    drain(0, C_ELEMS);
    check("ident_start_pulses", start_cnt - s0, 1);
    check("ident_busy_after", bus.busy, 1'b0);
    check("ident_queue_empty", exp_q.size(), 0);

    // signed
    for (int i = 0; i < A_ELEMS; i++) job_a[i] = 8'hFE;
    for (int i = 0; i < B_ELEMS; i++) job_b[i] = 8'h03;
    send_job(0, 1'b1, 1'b0);
    check("signed_mm_a", bus.mm_a, {A_ELEMS{8'hFE}});
    check("signed_mm_b", bus.mm_b, {B_ELEMS{8'h03}});
    drain(0, C_ELEMS);

    // backpressure on both streams
    random_operands();
    send_job(1, 1'b1, 1'b0);
    drain(1, C_ELEMS);
    check("bp_queue_empty", exp_q.size(), 0);
    check("bp_mm_a_held", bus.mm_a, a_flat);

    // stale DONE
    mult_mode = M_STALE;
    random_operands();
    send_job(0, 1'b1, 1'b0);
    wait_start();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    repeat (6) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("stale_no_early_capture", bus.out_valid, 1'b0);
    check("stale_state_wait", bus.dbg_state, WAIT);
    check("stale_in_ready", bus.in_ready, 1'b0);
    check("stale_mm_a_stable", bus.mm_a, a_flat);
    check("stale_mm_b_stable", bus.mm_b, b_flat);
    drain(0, C_ELEMS);
    mult_mode = M_NORMAL;

    // timeout
    mult_mode = M_NEVER;
    random_operands();
    send_job(0, 1'b0, 1'b0);
    wait_start();
    repeat (64) @(posedge clk);
    #1;
    check("to_err_before", bus.timeout_err, 1'b0);
    check("to_busy_before", bus.busy, 1'b1);
    @(posedge clk); #1;
    check("to_err_set", bus.timeout_err, 1'b1);
    check("to_in_ready", bus.in_ready, 1'b1);
    check("to_busy_low", bus.busy, 1'b0);
    check("to_state_load", bus.dbg_state, LOAD);
    mult_mode = M_NORMAL;
    random_operands();
    send_job(0, 1'b1, 1'b1);
    drain(2, C_ELEMS);

    // randomized jobs
    for (int t = 0; t < 4; t++) begin
      done_delay = $urandom_range(2, 8);
      random_operands();
      send_job(2, 1'b1, 1'b0);
      drain(2, C_ELEMS);
    end
    check("rand_queue_empty", exp_q.size(), 0);
    done_delay = 3;

    // reset in DRAIN after 4 outputs
    random_operands();
    send_job(0, 1'b1, 1'b0);
    drain(0, 4);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_out_data", bus.out_data, '0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    check("post_rst_in_ready", bus.in_ready, 1'b1);
    check("post_rst_state", bus.dbg_state, LOAD);
    random_operands();
    send_job(2, 1'b1, 1'b0);
    drain(2, C_ELEMS);
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
